// File: rtl/dmem_q15_fp16_streamer.sv
// Streams a window of the Q15 data-constant ROM out as IEEE-754 binary16 words.
// Two-stage pipeline (ROM capture, then conversion into the output register)
// advances on a single global enable, so back-pressure stalls everything in lockstep.
module dmem_q15_fp16_streamer #(
  parameter int unsigned AW = 9,
  parameter int unsigned LW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [LW-1:0] len,
  output logic [AW-1:0] mem_a,
  input  logic [15:0]   mem_q,
  output logic [15:0]   out_data,
  output logic          out_valid,
  output logic          out_last,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] mem_a_q, mem_a_d;
  logic [LW-1:0] rem_q, rem_d;
  logic          s1_valid_q, s1_valid_d;
  logic [DW-1:0] s1_data_q, s1_data_d;
  logic          s1_last_q, s1_last_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          en;

  // Q15 (value = q/32768) to binary16, round-to-nearest-even; never yields NaN/Inf.
  function automatic logic [DW-1:0] q15_to_fp16(input logic [DW-1:0] q);
    logic        sgn;
    logic [15:0] mag;
    logic [3:0]  p;
    logic [14:0] frac;
    logic        round_up;
    logic [10:0] mant_r;
    logic [4:0]  exp_f;
    logic [DW-1:0] res;
    sgn = q[15];
    // 0x8000 negates to itself, which reads correctly as unsigned 32768.
    mag = sgn ? 16'(~q + 16'd1) : q;
    p   = 4'd0;
    for (int i = 1; i < 15; i++) begin
      if (mag[i]) p = 4'(i);
    end
    // Left-align the bits below the leading one: [14:5] mantissa, [4] guard, [3:0] sticky.
    frac     = 15'(mag[14:0] << (5'd15 - {1'b0, p}));
    round_up = frac[4] & ((|frac[3:0]) | frac[5]);
    mant_r   = {1'b0, frac[14:5]} + 11'(round_up);
    exp_f    = {1'b0, p} + 5'(mant_r[10]);
    if (mag == 16'd0) begin
      res = 16'h0000;
    end else if (mag[15]) begin
      res = {sgn, 5'd15, 10'd0};
    end else if (mag == 16'd1) begin
      res = {sgn, 15'h0200};
    end else begin
      res = {sgn, exp_f, mant_r[9:0]};
    end
    return res;
  endfunction

  // State and pipeline registers; reset kills any stream in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_a_q     <= '0;
      rem_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_last_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_a_q     <= mem_a_d;
      rem_q       <= rem_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_last_q   <= s1_last_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state, issue and pipeline-advance logic.
  always_comb begin
    state_d     = state_q;
    mem_a_d     = mem_a_q;
    rem_d       = rem_q;
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_last_d   = s1_last_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    en          = !out_valid_q || out_ready;

    if (en) begin
      s1_valid_d  = 1'b0;
      out_valid_d = s1_valid_q;
      out_last_d  = s1_valid_q & s1_last_q;
      if (s1_valid_q) out_data_d = q15_to_fp16(s1_data_q);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (len != '0) begin
            mem_a_d = base;
            rem_d   = len;
            state_d = S_RUN;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (en) begin
          s1_valid_d = 1'b1;
          s1_data_d  = mem_q;
          s1_last_d  = (rem_q == LW'(1));
          mem_a_d    = mem_a_q + AW'(1);
          rem_d      = rem_q - LW'(1);
          if (rem_q == LW'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_valid_q && out_ready && out_last_q) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_a     = mem_a_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_dmem_q15_fp16_streamer.sv
// Bench for dmem_q15_fp16_streamer: stub ROM, reference converter and expected-beat queue.
module tb_dmem_q15_fp16_streamer;

  localparam int unsigned AW = 9;
  localparam int unsigned LW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [LW-1:0] len = '0;
  logic [AW-1:0] mem_a;
  logic [15:0]   mem_q;
  logic [15:0]   out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready = 1'b0;
  logic          busy;
  logic          done;

  logic [15:0] rom [0:511];
  logic [16:0] exp_q [$];
  int          n_cmp = 0;
  int          n_err = 0;

  dmem_q15_fp16_streamer #(.AW(AW), .LW(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
    .mem_a(mem_a), .mem_q(mem_q),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  assign mem_q = rom[mem_a];

  always #5 clk = ~clk;

  // Integer reference: q/32768 to binary16 with round-to-nearest-even.
  function automatic logic [15:0] fp16_model(input logic [15:0] q);
    int m, p, fr, d, mant, rem, half, e;
    logic s;
    s = q[15];
    m = s ? (65536 - int'(q)) : int'(q);
    if (m == 0) return 16'h0000;
    p = 15;
    while (((m >> p) & 1) == 0) p--;
    if (p == 0) return {s, 15'h0200};
    fr = m - (1 << p);
    e  = p;
    if (p <= 10) begin
      mant = fr << (10 - p);
    end else begin
      d    = p - 10;
      mant = fr >> d;
      rem  = fr & ((1 << d) - 1);
      half = 1 << (d - 1);
      if (rem > half || (rem == half && (mant & 1) == 1)) mant++;
      if (mant == 1024) begin
        mant = 0;
        e++;
      end
    end
    return {s, 5'(e), 10'(mant)};
  endfunction

  task automatic do_start(input logic [AW-1:0] b, input logic [LW-1:0] l);
    start = 1'b1;
    base  = b;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({mem_a, out_data, out_valid, out_last, busy, done} !== '0) begin
      n_err++;
      $display("FAIL reset_hold got mem_a=%0d data=%h v=%b l=%b busy=%b done=%b want all zero",
               mem_a, out_data, out_valid, out_last, busy, done);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, busy, done} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_release got v=%b busy=%b done=%b want 000", out_valid, busy, done);
    end
  endtask

  task automatic test_basic();
    int cyc, beat, first, done_cnt, done_cyc;
    logic [16:0] e;
    logic [15:0] ref_v;
    bit          have_ref;
    exp_q.delete();
    for (int i = 0; i < 20; i++) exp_q.push_back({(i == 19), fp16_model(rom[i])});
    out_ready = 1'b1;
    do_start(9'd0, 10'd20);
    cyc = 0; beat = 0; first = -1; done_cnt = 0; done_cyc = -1;
    while (cyc < 100 && (done_cyc < 0 || cyc <= done_cyc + 3)) begin
      if (out_valid && first < 0) first = cyc;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL basic_extra beat=%0d data=%h want no beat", beat, out_data);
        end else begin
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e) begin
            n_err++;
            $display("FAIL basic_beat%0d got last=%b data=%h want last=%b data=%h",
                     beat, out_last, out_data, e[16], e[15:0]);
          end
        end
        have_ref = 1'b1;
        case (beat)
          0:       ref_v = 16'h3C00;
          1:       ref_v = 16'h2E44;
          11:      ref_v = 16'hAE44;
          18:      ref_v = 16'hBC00;
          19:      ref_v = 16'h0000;
          default: begin ref_v = '0; have_ref = 1'b0; end
        endcase
        if (have_ref) begin
          n_cmp++;
          if (out_data !== ref_v) begin
            n_err++;
            $display("FAIL basic_const%0d got %h want %h", beat, out_data, ref_v);
          end
        end
        beat++;
      end
      if (cyc == 10) begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_err++;
          $display("FAIL basic_busy_mid got %b want 1", busy);
        end
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        n_cmp++;
        if (busy !== 1'b0) begin
          n_err++;
          $display("FAIL basic_busy_fall got %b want 0", busy);
        end
      end
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (first != 2) begin n_err++; $display("FAIL basic_latency got %0d want 2", first); end
    n_cmp++;
    if (beat != 20) begin n_err++; $display("FAIL basic_count got %0d want 20", beat); end
    n_cmp++;
    if (done_cnt != 1) begin n_err++; $display("FAIL basic_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] a_exp [4] = '{9'd510, 9'd511, 9'd0, 9'd1};
    int cyc, beat, done_cyc;
    logic [16:0] e;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), fp16_model(rom[a_exp[i]])});
    out_ready = 1'b1;
    do_start(9'd510, 10'd4);
    cyc = 0; beat = 0; done_cyc = -1;
    while (cyc < 60 && (done_cyc < 0 || cyc <= done_cyc + 2)) begin
      if (cyc < 4) begin
        n_cmp++;
        if (mem_a !== a_exp[cyc]) begin
          n_err++;
          $display("FAIL wrap_addr%0d got %0d want %0d", cyc, mem_a, a_exp[cyc]);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL wrap_extra data=%h want no beat", out_data);
        end else begin
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e) begin
            n_err++;
            $display("FAIL wrap_beat%0d got last=%b data=%h want last=%b data=%h",
                     beat, out_last, out_data, e[16], e[15:0]);
          end
        end
        beat++;
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (beat != 4) begin n_err++; $display("FAIL wrap_count got %0d want 4", beat); end
  endtask

  task automatic test_len0();
    int nv, nd, nb;
    nv = 0; nd = 0; nb = 0;
    out_ready = 1'b1;
    do_start(9'd5, 10'd0);
    for (int c = 0; c < 6; c++) begin
      if (out_valid) nv++;
      if (done) nd++;
      if (busy) nb++;
      @(negedge clk);
    end
    n_cmp++;
    if (nv != 0) begin n_err++; $display("FAIL len0_valid got %0d want 0", nv); end
    n_cmp++;
    if (nd != 1) begin n_err++; $display("FAIL len0_done got %0d want 1", nd); end
    n_cmp++;
    if (nb != 1) begin n_err++; $display("FAIL len0_busy got %0d want 1", nb); end
  endtask

  task automatic test_backpressure();
    int cyc, beat, done_cnt, done_cyc;
    logic [16:0] e;
    logic        stall, pl;
    logic [15:0] pd;
    exp_q.delete();
    for (int i = 0; i < 20; i++) exp_q.push_back({(i == 19), fp16_model(rom[i])});
    do_start(9'd0, 10'd20);
    cyc = 0; beat = 0; done_cnt = 0; done_cyc = -1; stall = 1'b0; pl = 1'b0; pd = '0;
    while (cyc < 150 && (done_cyc < 0 || cyc <= done_cyc + 2)) begin
      out_ready = (cyc % 2 == 0);
      if (stall) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
          n_err++;
          $display("FAIL bp_hold got v=%b data=%h last=%b want v=1 data=%h last=%b",
                   out_valid, out_data, out_last, pd, pl);
        end
      end
      stall = out_valid && !out_ready;
      pd    = out_data;
      pl    = out_last;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL bp_extra data=%h want no beat", out_data);
        end else begin
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e) begin
            n_err++;
            $display("FAIL bp_beat%0d got last=%b data=%h want last=%b data=%h",
                     beat, out_last, out_data, e[16], e[15:0]);
          end
        end
        beat++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b1;
    n_cmp++;
    if (beat != 20) begin n_err++; $display("FAIL bp_count got %0d want 20", beat); end
    n_cmp++;
    if (done_cnt != 1) begin n_err++; $display("FAIL bp_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_corners();
    logic [15:0] cin  [5] = '{16'h0001, 16'h4000, 16'hFFFF, 16'h8000, 16'h7FFF};
    logic [15:0] cout [5] = '{16'h0200, 16'h3800, 16'h8200, 16'hBC00, 16'h3C00};
    int cyc, beat, done_cyc;
    logic [16:0] e;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      rom[100 + i] = cin[i];
      exp_q.push_back({(i == 4), cout[i]});
    end
    out_ready = 1'b1;
    do_start(9'd100, 10'd5);
    cyc = 0; beat = 0; done_cyc = -1;
    while (cyc < 60 && (done_cyc < 0 || cyc <= done_cyc + 2)) begin
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL corner_extra data=%h want no beat", out_data);
        end else begin
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e) begin
            n_err++;
            $display("FAIL corner%0d q=%h got last=%b data=%h want last=%b data=%h",
                     beat, cin[beat % 5], out_last, out_data, e[16], e[15:0]);
          end
        end
        beat++;
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (beat != 5) begin n_err++; $display("FAIL corner_count got %0d want 5", beat); end
  endtask

  task automatic test_reset_midstream();
    int cyc, beat, done_cnt, done_cyc, busy_late;
    logic [16:0] e;
    exp_q.delete();
    for (int i = 0; i < 20; i++) exp_q.push_back({(i == 19), fp16_model(rom[i])});
    out_ready = 1'b1;
    do_start(9'd0, 10'd20);
    cyc = 0; beat = 0;
    while (beat < 7 && cyc < 60) begin
      if (out_valid && out_ready) begin
        n_cmp++;
        e = exp_q.pop_front();
        if ({out_last, out_data} !== e) begin
          n_err++;
          $display("FAIL rstmid_beat%0d got last=%b data=%h want last=%b data=%h",
                   beat, out_last, out_data, e[16], e[15:0]);
        end
        beat++;
      end
      @(negedge clk);
      cyc++;
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({mem_a, out_data, out_valid, out_last, busy, done} !== '0 || beat != 7) begin
      n_err++;
      $display("FAIL rstmid_async beat=%0d got mem_a=%0d data=%h v=%b l=%b busy=%b done=%b want all zero",
               beat, mem_a, out_data, out_valid, out_last, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({out_valid, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL rstmid_noresume got v=%b busy=%b want 00", out_valid, busy);
    end

    exp_q.delete();
    exp_q.push_back({1'b0, 16'h3C00});
    exp_q.push_back({1'b1, 16'h2E44});
    do_start(9'd0, 10'd2);
    cyc = 0; beat = 0; done_cnt = 0; done_cyc = -1; busy_late = 0;
    while (cyc < 60 && (done_cyc < 0 || cyc <= done_cyc + 8)) begin
      if (cyc == 1) begin
        start = 1'b1;
        base  = 9'd300;
        len   = 10'd5;
      end else begin
        start = 1'b0;
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL restart_extra data=%h want no beat", out_data);
        end else begin
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e) begin
            n_err++;
            $display("FAIL restart_beat%0d got last=%b data=%h want last=%b data=%h",
                     beat, out_last, out_data, e[16], e[15:0]);
          end
        end
        beat++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc > done_cyc && busy) busy_late++;
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (beat != 2) begin n_err++; $display("FAIL restart_count got %0d want 2", beat); end
    n_cmp++;
    if (done_cnt != 1) begin n_err++; $display("FAIL restart_done got %0d want 1", done_cnt); end
    n_cmp++;
    if (busy_late != 0) begin
      n_err++;
      $display("FAIL busy_start_ignored got %0d busy cycles after done want 0", busy_late);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = 16'($urandom);
    rom[0]   = 16'h7FFF;
    rom[1]   = 16'h0C88;
    rom[11]  = 16'hF378;
    rom[18]  = 16'h8000;
    rom[19]  = 16'h0000;
    rom[510] = 16'h0336;
    rom[511] = 16'hF378;

    test_reset();
    test_basic();
    test_wrap();
    test_len0();
    test_backpressure();
    test_corners();
    test_reset_midstream();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_q15_fp16_streamer.md
Name: dmem_q15_fp16_streamer

Overview:
- Downstream consumer of the 512x16 Q15 data-constant ROM (combinational, 9-bit address `a`, 16-bit `q`).
- On a start pulse it walks a programmable address window, reading the ROM and converting each Q15 word to IEEE-754 binary16.
- Results go out on a valid/ready stream into the FPU operand path.
- Replaces software-side Q15 to FP16 conversion of test and coefficient data.

Parameters:
- AW, 9: ROM address width; address arithmetic is modulo 2^AW.
- LW, 10: length field width; max length 2^AW = 512.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request; sampled only in IDLE
- base  in  AW  first ROM address
- len  in  LW  element count, 0..512
- mem_a  out  AW  address to ROM `a`
- mem_q  in  16  ROM `q` data (combinational from mem_a)
- out_data  out  16  FP16 result
- out_valid  out  1  out_data valid
- out_last  out  1  marks final element
- out_ready  in  1  consumer accept
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after last element accepted

Behaviour:
- Reset (async, asserts immediately, mid-operation included): FSM=IDLE; mem_a=0; out_data=0; out_valid=0; out_last=0; busy=0; done=0; pipeline valids cleared. No partial stream resumes after reset.
- FSM states IDLE, RUN, DRAIN, DONE.
  - IDLE + start + len!=0: mem_a<=base, remaining<=len, busy<=1, go to RUN.
  - IDLE + start + len==0: go to DONE with no output; done pulses the next cycle.
  - start while busy is ignored.
- Pipeline global enable: en = !out_valid | out_ready. When en=0, mem_a, stage-1 and the output register all hold.
- RUN, each en cycle:
  - Stage-1 captures mem_q, with last = (remaining==1).
  - mem_a <= mem_a+1 mod 512 (wraps 511 to 0).
  - remaining decrements.
  - At remaining==1, go to DRAIN.
- DRAIN: no new issue; wait until the output register holds last and is accepted (out_valid & out_ready & out_last), then go to DONE.
- DONE: done=1 for exactly one cycle, busy<=0, go to IDLE.
- Latency and throughput:
  - Start sampled at edge T0: mem_a=base after T0, stage-1 valid after T1, out_valid after T2.
  - With out_ready held high, one element per cycle.
  - Back-pressure never drops or duplicates data.
- out_valid, once high, stays high with out_data and out_last stable until accepted.
- Q15 to FP16 conversion, registered in the output stage:
  - Value = signed q / 32768.
  - Sign = q[15]; magnitude m = |q|, 17-bit safe (0x8000 gives m=32768).
  - m==0: 0x0000.
  - m==32768: 0xBC00 (-1.0).
  - m==1: subnormal 0x0200.
  - Otherwise normalise on leading-one position p (1..14): exponent = p; mantissa = next 10 bits below the leading one, zero-padded.
  - Round-to-nearest-even on the dropped bits; mantissa overflow increments the exponent (0x7FFF gives 0x3C00).
  - No NaN/Inf is ever produced.
- busy is high in RUN, DRAIN and DONE.

Test Plan:
- Reset, then start base=0 len=20, out_ready=1: 20 beats starting 2 cycles after start. Beat0 0x3C00, beat1 0x2E44, beat11 0xAE44, beat18 0xBC00, beat19 0x0000 with out_last=1. done pulses once, busy falls the same cycle as done.
- base=510 len=4: mem_a sequence 510, 511, 0, 1; out_data converts q words 0x0336, 0xF378, 0x7FFF, 0x0C88 (addresses 510, 511, 0, 1).
- len=0: no out_valid; done pulses once; busy high for exactly one cycle.
- out_ready toggled 1010... during len=20: all 20 values delivered in order, none lost or duplicated. out_data and out_last stable while out_valid & !out_ready.
- Conversion corners via a stub ROM: 0x0001 gives 0x0200, 0x4000 gives 0x3800, 0xFFFF gives 0x8200, 0x8000 gives 0xBC00, 0x7FFF gives 0x3C00.
- Assert rst mid-stream (beat 7 of 20): outputs zero immediately. A new start base=0 len=2 then yields 0x3C00, 0x2E44 with last on beat 1. A start pulse issued while busy has no effect.
